// File: rtl/subpel_pkg.sv
// Shared types and constants for the sub-pel row sequencer.
// State encoding, block geometry and fractional-phase encodings.
package subpel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int SUBPEL_ROWS = 15;
  localparam int SUBPEL_BLK  = 8;

  localparam logic [1:0] FRAC_A   = 2'd0;
  localparam logic [1:0] FRAC_B   = 2'd1;
  localparam logic [1:0] FRAC_C   = 2'd2;
  localparam logic [1:0] FRAC_ALL = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/subpel_perf_cnt.sv
// Block and stall event counters for the row sequencer.
// Only built when SUBPEL_SEQ_PERF_EN is defined.
module subpel_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_done,
  input  logic        i_stall_evt,
  output logic [15:0] o_blk_count,
  output logic [15:0] o_stall_count
);

  logic [15:0] r_blk;
  logic [15:0] r_stl;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk <= '0;
      r_stl <= '0;
    end else begin
      if (i_done)      r_blk <= r_blk + 16'd1;
      if (i_stall_evt) r_stl <= r_stl + 16'd1;
    end
  end

  assign o_blk_count   = r_blk;
  assign o_stall_count = r_stl;

endmodule

// File: rtl/subpel_row_sequencer.sv
// Sequences the sub-pixel interpolation datapath over one 8x8 block.
// Optional perf counters: define SUBPEL_SEQ_PERF_EN.
module subpel_row_sequencer
  import subpel_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] blk_base,
  input  logic [1:0]        frac_mode,
  input  logic              stall,
  output logic [ADDR_W-1:0] row_addr,
  output logic [3:0]        row_idx,
  output logic              fir_load,
  output logic [1:0]        frac_sel,
  output logic              out_load,
  output logic              done,
  output logic              busy,
  output logic [7:0]        cnt
`ifdef SUBPEL_SEQ_PERF_EN
  ,
  output logic [15:0]       blk_count,
  output logic [15:0]       stall_count
`endif
);

  localparam logic [3:0] LAST_ROW   = 4'(SUBPEL_ROWS - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_frac;
  logic [3:0]        r_row_cnt;
  logic [3:0]        r_drain;
  logic [7:0]        r_cnt;
  logic              w_fetch;
  logic              w_accept;
  logic              w_last;

  assign w_fetch  = (r_state == ST_FETCH);
  assign w_accept = start_valid && (r_state == ST_IDLE);
  assign w_last   = fir_load && (r_row_cnt == LAST_ROW);

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start_valid) w_next = ST_FETCH;
      ST_FETCH: if (w_last) w_next = ST_DRAIN;
      ST_DRAIN: if (!stall && r_drain == 4'd0) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Block context, row/drain counters and cycle counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base    <= '0;
      r_frac    <= '0;
      r_row_cnt <= '0;
      r_drain   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_base    <= blk_base;
        r_frac    <= frac_mode;
        r_row_cnt <= '0;
        // the handshake cycle itself counts, so the first FETCH cycle reads 1
        r_cnt     <= 8'd1;
      end else begin
        if (fir_load) r_row_cnt <= r_row_cnt + 4'd1;
        if (r_state != ST_IDLE) r_cnt <= sat_inc8(r_cnt);
      end
      if (w_last)
        r_drain <= DRAIN_INIT;
      else if (r_state == ST_DRAIN && !stall && r_drain != 4'd0)
        r_drain <= r_drain - 4'd1;
    end
  end

  assign start_ready = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign fir_load    = w_fetch && !stall;
  assign row_idx     = w_fetch ? r_row_cnt : 4'd0;
  assign row_addr    = w_fetch ? r_base + ADDR_W'(r_row_cnt) : '0;
  assign frac_sel    = r_frac;
  assign out_load    = (r_state == ST_DONE);
  assign done        = (r_state == ST_DONE);
  assign cnt         = r_cnt;

`ifdef SUBPEL_SEQ_PERF_EN
  logic w_stall_evt;
  assign w_stall_evt = stall && (w_fetch || r_state == ST_DRAIN);

  subpel_perf_cnt u_perf (
    .clk           (clk),
    .rst           (rst),
    .i_done        (done),
    .i_stall_evt   (w_stall_evt),
    .o_blk_count   (blk_count),
    .o_stall_count (stall_count)
  );
`endif

endmodule

// File: tb/tb_subpel_row_sequencer.sv
// Directed self-checking bench for subpel_row_sequencer.
// Perf counter test is built when SUBPEL_SEQ_PERF_EN is defined.
module tb_subpel_row_sequencer;
  import subpel_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_valid = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] blk_base = 8'h00;
  logic [1:0] frac_mode = 2'd0;
  logic       start_ready;
  logic [7:0] row_addr;
  logic [3:0] row_idx;
  logic       fir_load;
  logic [1:0] frac_sel;
  logic       out_load;
  logic       done;
  logic       busy;
  logic [7:0] cnt;
`ifdef SUBPEL_SEQ_PERF_EN
  logic [15:0] blk_count;
  logic [15:0] stall_count;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] a_addr[320];
  logic [3:0] a_idx[320];
  logic       a_load[320];
  logic       a_done[320];
  logic       a_oload[320];
  logic       a_ready[320];
  logic       a_busy[320];
  logic [1:0] a_frac[320];
  logic [7:0] a_cnt[320];

  subpel_row_sequencer #(.ADDR_W(8), .PIPE_LAT(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .blk_base    (blk_base),
    .frac_mode   (frac_mode),
    .stall       (stall),
    .row_addr    (row_addr),
    .row_idx     (row_idx),
    .fir_load    (fir_load),
    .frac_sel    (frac_sel),
    .out_load    (out_load),
    .done        (done),
    .busy        (busy),
    .cnt         (cnt)
`ifdef SUBPEL_SEQ_PERF_EN
    ,
    .blk_count   (blk_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Drive n cycles starting at cycle 0 (handshake), recording outputs.
  task automatic run_blk(input logic [7:0] base, input logic [1:0] mode,
                         input bit hold, input int s1_lo, input int s1_n,
                         input int s2_lo, input int s2_n, input int n);
    for (int c = 0; c < n; c++) begin
      start_valid = (c == 0) || hold;
      blk_base    = base;
      frac_mode   = mode;
      stall = ((c >= s1_lo) && (c < s1_lo + s1_n)) ||
              ((c >= s2_lo) && (c < s2_lo + s2_n));
      #1;
      a_addr[c]  = row_addr;
      a_idx[c]   = row_idx;
      a_load[c]  = fir_load;
      a_done[c]  = done;
      a_oload[c] = out_load;
      a_ready[c] = start_ready;
      a_busy[c]  = busy;
      a_frac[c]  = frac_sel;
      a_cnt[c]   = cnt;
      @(posedge clk);
      #2;
    end
    start_valid = 1'b0;
    stall = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    start_valid = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || fir_load !== 1'b0 ||
        out_load !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b load=%b oload=%b done=%b want 1 0 0 0 0",
               start_ready, busy, fir_load, out_load, done);
    end
    checks++;
    if (row_idx !== 4'd0 || row_addr !== 8'd0 || frac_sel !== 2'd0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_data: idx=%0d addr=%h frac=%0d cnt=%0d want zeros",
               row_idx, row_addr, frac_sel, cnt);
    end
  endtask

  task automatic test_basic();
    logic e;
    apply_reset();
    run_blk(8'h10, 2'd2, 1'b0, 0, 0, 0, 0, 22);
    checks++;
    if (a_ready[0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready0: got %b want 1", a_ready[0]);
    end
    for (int c = 0; c < 22; c++) begin
      e = (c >= 1 && c <= 15);
      checks++;
      if (a_load[c] !== e) begin
        failures++;
        $display("FAIL basic_load c=%0d: got %b want %b", c, a_load[c], e);
      end
      if (e) begin
        checks++;
        if (a_addr[c] !== 8'(8'h10 + c - 1) || a_idx[c] !== 4'(c - 1)) begin
          failures++;
          $display("FAIL basic_addr c=%0d: got %h/%0d want %h/%0d",
                   c, a_addr[c], a_idx[c], 8'(8'h10 + c - 1), c - 1);
        end
      end
      e = (c == 19);
      checks++;
      if (a_done[c] !== e || a_oload[c] !== e) begin
        failures++;
        $display("FAIL basic_done c=%0d: done=%b oload=%b want %b",
                 c, a_done[c], a_oload[c], e);
      end
      if (c >= 1 && c <= 19) begin
        checks++;
        if (a_frac[c] !== 2'd2 || a_busy[c] !== 1'b1) begin
          failures++;
          $display("FAIL basic_frac c=%0d: frac=%0d busy=%b want 2 1",
                   c, a_frac[c], a_busy[c]);
        end
      end
    end
    checks++;
    if (a_cnt[19] !== 8'd19) begin
      failures++;
      $display("FAIL basic_cnt: got %0d want 19", a_cnt[19]);
    end
  endtask

  task automatic test_stall();
    int k;
    apply_reset();
    run_blk(8'h20, 2'd1, 1'b0, 8, 4, 20, 2, 30);
    k = 0;
    for (int c = 0; c < 30; c++) begin
      if (a_load[c]) begin
        checks++;
        if (a_idx[c] !== 4'(k) || a_addr[c] !== 8'(8'h20 + k)) begin
          failures++;
          $display("FAIL stall_seq c=%0d: got %0d/%h want %0d/%h",
                   c, a_idx[c], a_addr[c], k, 8'(8'h20 + k));
        end
        k++;
      end
      checks++;
      if (a_done[c] !== (c == 25)) begin
        failures++;
        $display("FAIL stall_done c=%0d: got %b want %b", c, a_done[c], c == 25);
      end
    end
    checks++;
    if (k !== 15) begin
      failures++;
      $display("FAIL stall_nloads: got %0d want 15", k);
    end
    for (int c = 8; c <= 12; c++) begin
      checks++;
      if (a_idx[c] !== 4'd7 || a_load[c] !== (c == 12)) begin
        failures++;
        $display("FAIL stall_hold c=%0d: idx=%0d load=%b want 7 %b",
                 c, a_idx[c], a_load[c], c == 12);
      end
    end
    checks++;
    if (a_cnt[25] !== 8'd25) begin
      failures++;
      $display("FAIL stall_cnt: got %0d want 25", a_cnt[25]);
    end
  endtask

  task automatic test_wrap();
    int k;
    apply_reset();
    run_blk(8'hF8, 2'd0, 1'b0, 0, 0, 0, 0, 22);
    k = 0;
    for (int c = 0; c < 22; c++) begin
      if (a_load[c]) begin
        checks++;
        if (a_addr[c] !== 8'(8'hF8 + k)) begin
          failures++;
          $display("FAIL wrap_addr k=%0d: got %h want %h", k, a_addr[c], 8'(8'hF8 + k));
        end
        k++;
      end
    end
    checks++;
    if (k !== 15) begin
      failures++;
      $display("FAIL wrap_nloads: got %0d want 15", k);
    end
  endtask

  task automatic test_back_to_back();
    logic e;
    apply_reset();
    run_blk(8'h00, 2'd3, 1'b1, 0, 0, 0, 0, 23);
    for (int c = 0; c < 23; c++) begin
      e = (c == 0 || c == 20);
      checks++;
      if (a_ready[c] !== e) begin
        failures++;
        $display("FAIL b2b_ready c=%0d: got %b want %b", c, a_ready[c], e);
      end
    end
    checks++;
    if (a_load[21] !== 1'b1 || a_idx[21] !== 4'd0 || a_idx[22] !== 4'd1) begin
      failures++;
      $display("FAIL b2b_second: load=%b idx=%0d,%0d want 1 0,1",
               a_load[21], a_idx[21], a_idx[22]);
    end
  endtask

  task automatic test_cnt_sat();
    apply_reset();
    run_blk(8'h00, 2'd0, 1'b0, 1, 270, 0, 0, 275);
    checks++;
    if (a_cnt[200] !== 8'd200 || a_cnt[255] !== 8'd255 || a_cnt[274] !== 8'd255) begin
      failures++;
      $display("FAIL cnt_sat: got %0d,%0d,%0d want 200,255,255",
               a_cnt[200], a_cnt[255], a_cnt[274]);
    end
    checks++;
    if (a_idx[270] !== 4'd0 || a_load[270] !== 1'b0 || a_load[271] !== 1'b1) begin
      failures++;
      $display("FAIL cnt_sat_hold: idx=%0d load=%b,%b want 0 0,1",
               a_idx[270], a_load[270], a_load[271]);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    apply_reset();
    run_blk(8'h30, 2'd3, 1'b0, 0, 0, 0, 0, 6);
    #1;
    checks++;
    if (row_idx !== 4'd5 || fir_load !== 1'b1) begin
      failures++;
      $display("FAIL rmid_pre: idx=%0d load=%b want 5 1", row_idx, fir_load);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || fir_load !== 1'b0 || done !== 1'b0 ||
        row_idx !== 4'd0 || row_addr !== 8'd0 || frac_sel !== 2'd0 || cnt !== 8'd0) begin
      failures++;
      $display("FAIL rmid_reset: rdy=%b busy=%b ld=%b dn=%b idx=%0d addr=%h frac=%0d cnt=%0d",
               start_ready, busy, fir_load, done, row_idx, row_addr, frac_sel, cnt);
    end
    repeat (3) begin
      @(posedge clk);
      #2;
      checks++;
      if (done !== 1'b0 || out_load !== 1'b0) begin
        failures++;
        $display("FAIL rmid_nodone: done=%b oload=%b want 0 0", done, out_load);
      end
    end
    rst = 1'b0;
    run_blk(8'h40, 2'd1, 1'b0, 0, 0, 0, 0, 22);
    k = 0;
    for (int c = 0; c < 22; c++) begin
      if (a_load[c]) begin
        checks++;
        if (a_addr[c] !== 8'(8'h40 + k)) begin
          failures++;
          $display("FAIL rmid_addr k=%0d: got %h want %h", k, a_addr[c], 8'(8'h40 + k));
        end
        k++;
      end
      checks++;
      if (a_done[c] !== (c == 19)) begin
        failures++;
        $display("FAIL rmid_done c=%0d: got %b want %b", c, a_done[c], c == 19);
      end
    end
    checks++;
    if (k !== 15 || a_frac[10] !== 2'd1) begin
      failures++;
      $display("FAIL rmid_after: loads=%0d frac=%0d want 15 1", k, a_frac[10]);
    end
  endtask

`ifdef SUBPEL_SEQ_PERF_EN
  task automatic test_perf();
    apply_reset();
    run_blk(8'h00, 2'd0, 1'b0, 3, 2, 0, 0, 23);
    run_blk(8'h10, 2'd1, 1'b0, 5, 1, 17, 1, 23);
    run_blk(8'h20, 2'd2, 1'b0, 16, 2, 0, 0, 23);
    checks++;
    if (blk_count !== 16'd3 || stall_count !== 16'd6) begin
      failures++;
      $display("FAIL perf: blk=%0d stall=%0d want 3 6", blk_count, stall_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_cnt_sat();
    test_reset_mid();
`ifdef SUBPEL_SEQ_PERF_EN
    test_perf();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/subpel_row_sequencer.md
# subpel_row_sequencer

Controller that sequences the `subpixel_interpolation` datapath for one 8x8 prediction block at a time. It accepts a block request through a valid/ready handshake and walks the 15 integer-pixel rows (8 + 7 filter taps) out of the row store. It drives the row index and load strobe into the datapath, waits out the FIR pipeline, then issues the output-load/done pulse. It sits between the block scheduler and `subpixel_interpolation`. It replaces the testbench-driven `next_row` stepping.

## Interface
- `ADDR_W`, 8 — row-store address width.
- `PIPE_LAT`, 3 — datapath cycles from the last row load to valid A/B/C arrays. Legal range 1..15.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — reset, asynchronous, active-high.
- `start_valid` in 1 — block request valid.
- `start_ready` out 1 — controller can accept a request.
- `blk_base` in ADDR_W — row-store address of the block's row 0; sampled on accept.
- `frac_mode` in 2 — fractional phase for the block (0=a, 1=b, 2=c, 3=all); sampled on accept.
- `stall` in 1 — datapath back-pressure; freezes sequencing.
- `row_addr` out ADDR_W — row-store read address (combinational read, same-cycle data).
- `row_idx` out 4 — current row 0..14 into the datapath.
- `fir_load` out 1 — `in_row` is valid and consumed this cycle.
- `frac_sel` out 2 — latched `frac_mode`, held for the whole block.
- `out_load` out 1 — one-cycle pulse: datapath latches its A/B/C output arrays.
- `done` out 1 — one-cycle pulse, coincident with `out_load`.
- `busy` out 1 — high in any state other than IDLE.
- `cnt` out 8 — cycles since accept, saturating at 255.

## Operation
- States and transitions:
  - IDLE: go to FETCH when `start_valid` is high, since `start_ready` is always 1 in IDLE.
  - FETCH: go to DRAIN after row 14 loads.
  - DRAIN: go to DONE when the drain counter expires.
  - DONE: go to IDLE unconditionally.
- `start_ready` = (state==IDLE), decoded combinationally. Requests are never accepted in other states.
- On accept, register `blk_base` and `frac_mode`, clear `row_cnt` and `cnt`.
- FETCH:
  - `row_idx` = `row_cnt`; `row_addr` = `blk_base` + `row_cnt`, modulo 2^ADDR_W (wraps silently).
  - `fir_load` = !`stall`.
  - `row_cnt` increments only when `fir_load` is high.
- DRAIN:
  - The counter loads PIPE_LAT-1 on entry and decrements when `stall` is low.
  - Exit occurs when the counter is 0 and `stall` is low.
  - `fir_load` is 0.
- DONE: `out_load` = `done` = 1 for exactly one cycle; `stall` is ignored.
- `cnt` increments every non-IDLE cycle, including stalled cycles, and saturates at 255. It holds its last value in IDLE until the next accept.
- `stall` has no effect in IDLE or DONE.
- Reset asserted mid-block aborts immediately, with no `done` pulse.

## Timing
- Reset values (asynchronous, while `rst`=1):
  - state IDLE;
  - `start_ready`=1;
  - `busy`=`fir_load`=`out_load`=`done`=0;
  - `row_idx`=0, `row_addr`=0, `frac_sel`=0, `cnt`=0.
- Cycle 0 is the handshake cycle in IDLE.
- Without stalls:
  - cycles 1..15 are FETCH, rows 0..14;
  - cycles 16..15+PIPE_LAT are DRAIN;
  - cycle 16+PIPE_LAT is DONE (cycle 19 at the default);
  - the next accept can occur at cycle 17+PIPE_LAT at the earliest.
- Each stalled cycle in FETCH or DRAIN adds exactly one cycle to the latency.
- `row_idx`, `row_addr`, `fir_load` and `frac_sel` are valid from the rising edge that enters the state. They are registered state decodes, and `fir_load` additionally depends combinationally on `stall`.

## Configuration
- `SUBPEL_SEQ_PERF_EN` defined: adds two outputs.
  - `blk_count` (16 bits) increments on each `done`.
  - `stall_count` (16 bits) increments on each cycle with `stall`=1 in FETCH or DRAIN.
  - Both counters wrap at 2^16 and reset to 0.
- Not defined: both ports and both counters are absent; all other behaviour is identical.

## Structure
- `subpel_pkg` holds:
  - the state enum (IDLE/FETCH/DRAIN/DONE);
  - `SUBPEL_ROWS`=15, `SUBPEL_BLK`=8;
  - the `frac_mode` encodings.
- Sub-module `subpel_perf_cnt` holds the two perf counters. It is instantiated only under `SUBPEL_SEQ_PERF_EN`.

## Test plan
- Basic block: reset, then `start_valid` with `blk_base`=0x10, `frac_mode`=2, no stall.
  - `fir_load` is high in cycles 1..15 with `row_addr` 0x10..0x1E.
  - `frac_sel`=2 throughout the block.
  - `done`/`out_load` pulse at cycle 19; `cnt`=19 at `done`.
- Stall: hold `stall`=1 for 4 cycles at row 7 and for 2 cycles in DRAIN.
  - `row_idx` holds at 7 while stalled.
  - No row is skipped or repeated-loaded.
  - `done` arrives at cycle 25.
- Address wrap: `blk_base`=0xF8 with ADDR_W=8.
  - `row_addr` sequence is F8..FF then 00..06.
- Back-to-back: hold `start_valid` high continuously.
  - Accepts occur at cycle 0 and cycle 20.
  - `start_ready` is 0 in cycles 1..19.
- Reset mid-block: assert `rst` at row 5.
  - Outputs go to reset values immediately.
  - No `done` pulse.
  - A new request after reset completes normally.
- Perf (with `SUBPEL_SEQ_PERF_EN`): run 3 blocks with a total of 6 stall cycles.
  - `blk_count`=3, `stall_count`=6.
